// File: rtl/npu_bram_pkg.sv
// Shared BRAM-path definitions: FSM state encoding and default matrix geometry,
// common to the BRAM reader and the BRAM writer.
package npu_bram_pkg;

  localparam int unsigned DEF_ROWS   = 32;
  localparam int unsigned DEF_COLS   = 32;
  localparam int unsigned DEF_IN_W   = 32;
  localparam int unsigned DEF_OUT_W  = 8;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned MAT_ELEMS  = DEF_ROWS * DEF_COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } bram_fsm_t;

endpackage

// File: rtl/sat_narrow.sv
// Signed element narrowing IN_W -> OUT_W (combinational).
// Build option FSM_BRAM_WRITER_SAT_EN: defined -> saturate to the signed OUT_W
// range; undefined -> keep the low OUT_W bits (two's-complement wrap).
module sat_narrow #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout_c
);

`ifdef FSM_BRAM_WRITER_SAT_EN
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  // Clamp out-of-range values to the nearest representable OUT_W value
  always_comb begin
    dout_c = din[OUT_W-1:0];
    if (din > MAX_V) begin
      dout_c = MAX_V[OUT_W-1:0];
    end else if (din < MIN_V) begin
      dout_c = MIN_V[OUT_W-1:0];
    end
  end
`else
  // Upper bits are intentionally discarded by the wrap behaviour
  logic unused_hi_c;
  assign unused_hi_c = ^din[IN_W-1:OUT_W];

  // Keep the low OUT_W bits
  always_comb begin
    dout_c = din[OUT_W-1:0];
  end
`endif

endmodule

// File: rtl/fsm_bram_writer_dual.sv
// Write-back of two ROWSxCOLS result matrices into two BRAMs over a shared
// row-major address (addr = r*COLS + c). Both matrices are snapshotted on
// start, then one element pair is written per cycle, narrowed IN_W -> OUT_W.
// Narrowing mode is selected by the FSM_BRAM_WRITER_SAT_EN macro (see sat_narrow).
module fsm_bram_writer_dual
  import npu_bram_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROWS*COLS*IN_W-1:0]     matrixA,
  input  logic [ROWS*COLS*IN_W-1:0]     matrixB,
  output logic                          bram_we,
  output logic [ADDR_W-1:0]             bram_addr,
  output logic signed [OUT_W-1:0]       bram_dataA,
  output logic signed [OUT_W-1:0]       bram_dataB,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned NUM_ELEMS = ROWS * COLS;
  localparam int unsigned IDX_W     = ADDR_W + 1;
  localparam int unsigned SEL_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  bram_fsm_t                         state;
  logic [IDX_W-1:0]                  idx;
  logic [NUM_ELEMS-1:0][IN_W-1:0]    snap_a;
  logic [NUM_ELEMS-1:0][IN_W-1:0]    snap_b;
  logic [SEL_W-1:0]                  idx_sel_c;
  logic signed [OUT_W-1:0]           narrow_a_c;
  logic signed [OUT_W-1:0]           narrow_b_c;

  assign idx_sel_c = SEL_W'(idx);

  // Capture both source matrices on the accepted start edge; not reset by design
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      snap_a <= matrixA;
      snap_b <= matrixB;
    end
  end

  sat_narrow #(.IN_W(IN_W), .OUT_W(OUT_W)) u_narrow_a (
    .din    (snap_a[idx_sel_c]),
    .dout_c (narrow_a_c)
  );

  sat_narrow #(.IN_W(IN_W), .OUT_W(OUT_W)) u_narrow_b (
    .din    (snap_b[idx_sel_c]),
    .dout_c (narrow_b_c)
  );

  // Transfer FSM with registered write port, busy and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_dataA <= '0;
      bram_dataB <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          idx   <= '0;
          state <= WRITE;
        end
        WRITE: begin
          bram_we    <= 1'b1;
          bram_addr  <= ADDR_W'(idx);
          bram_dataA <= narrow_a_c;
          bram_dataB <= narrow_b_c;
          idx        <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_bram_writer_dual.sv
// Self-checking bench for fsm_bram_writer_dual: behavioural BRAM image and
// narrowing model, directed scenarios with random matrix contents.
`timescale 1ns/1ps
module tb_fsm_bram_writer_dual;

  localparam int ROWS   = 32;
  localparam int COLS   = 32;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 8;
  localparam int ADDR_W = 10;
  localparam int N      = ROWS * COLS;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [N*IN_W-1:0]       mat_a;
  logic [N*IN_W-1:0]       mat_b;
  logic                    bram_we;
  logic [ADDR_W-1:0]       bram_addr;
  logic signed [OUT_W-1:0] bram_dataA;
  logic signed [OUT_W-1:0] bram_dataB;
  logic                    busy;
  logic                    done;

  int checks   = 0;
  int failures = 0;

  int exp_a [N];
  int exp_b [N];
  int got_a [N];
  int got_b [N];

  always #5 clk = ~clk;

  fsm_bram_writer_dual #(
    .ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .matrixA    (mat_a),
    .matrixB    (mat_b),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_dataA (bram_dataA),
    .bram_dataB (bram_dataB),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference narrowing, plain integer arithmetic
  function automatic int narrow(input longint v);
    longint lim;
    longint m;
    lim = longint'(1) << (OUT_W - 1);
`ifdef FSM_BRAM_WRITER_SAT_EN
    m = v;
    if (m > lim - 1) m = lim - 1;
    if (m < -lim) m = -lim;
`else
    m = v % (2 * lim);
    if (m < 0) m = m + 2 * lim;
    if (m >= lim) m = m - 2 * lim;
`endif
    return int'(m);
  endfunction

  task automatic set_elem(input bit is_b, input int r, input int c, input int v);
    if (is_b) mat_b[(r*COLS+c)*IN_W +: IN_W] = v;
    else      mat_a[(r*COLS+c)*IN_W +: IN_W] = v;
  endtask

  task automatic compute_expected();
    logic signed [IN_W-1:0] ea;
    logic signed [IN_W-1:0] eb;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        ea = mat_a[(r*COLS+c)*IN_W +: IN_W];
        eb = mat_b[(r*COLS+c)*IN_W +: IN_W];
        exp_a[r*COLS+c] = narrow(longint'(ea));
        exp_b[r*COLS+c] = narrow(longint'(eb));
      end
    end
  endtask

  task automatic randomize_mats();
    for (int i = 0; i < N; i++) begin
      mat_a[i*IN_W +: IN_W] = $urandom;
      mat_b[i*IN_W +: IN_W] = $urandom_range(0, 600) - 300;
    end
  endtask

  // Run one full transfer from IDLE and score it against the BRAM image model
  task automatic run_pass(input string tag, input bit hold, input bit zero_after, input bit pulse);
    int k, wcount, first_k, last_k, done_k, addr_err, busy_err, data_err;
    bit pulsed, saw_done;
    k = 0; wcount = 0; first_k = -1; last_k = -1; done_k = -1;
    addr_err = 0; busy_err = 0; data_err = 0; pulsed = 0; saw_done = 0;
    compute_expected();
    for (int i = 0; i < N; i++) begin
      got_a[i] = 9999;
      got_b[i] = 9999;
    end
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    if (zero_after) begin
      mat_a = '0;
      mat_b = '0;
    end
    while (!saw_done && k < N + 20) begin
      if (pulsed) start = 1'b0;
      if (bram_we === 1'b1) begin
        if (int'(bram_addr) != wcount) addr_err++;
        got_a[bram_addr] = int'(bram_dataA);
        got_b[bram_addr] = int'(bram_dataB);
        if (wcount == 0) first_k = k;
        last_k = k;
        wcount++;
        if (pulse && !pulsed && int'(bram_addr) == 500) begin
          start  = 1'b1;
          pulsed = 1'b1;
        end
      end
      if (done === 1'b1) begin
        saw_done = 1'b1;
        done_k   = k;
        check({tag, ".busy_at_done"}, 64'(busy), 0);
      end else if (busy !== 1'b1) begin
        busy_err++;
      end
      if (!saw_done) begin
        tick();
        k++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (got_a[i] != exp_a[i] || got_b[i] != exp_b[i]) data_err++;
    end
    check({tag, ".done_seen"}, 64'(saw_done), 1);
    check({tag, ".done_cycle"}, done_k, N + 2);
    check({tag, ".write_count"}, wcount, N);
    check({tag, ".first_write_cycle"}, first_k, 2);
    check({tag, ".last_write_cycle"}, last_k, N + 1);
    check({tag, ".addr_order_errors"}, addr_err, 0);
    check({tag, ".busy_errors"}, busy_err, 0);
    check({tag, ".bram_data_errors"}, data_err, 0);
  endtask

  initial begin
    int bad;
    int k;
    rst   = 1'b1;
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;
    repeat (3) tick();
    check("reset.we", 64'(bram_we), 0);
    check("reset.busy", 64'(busy), 0);
    check("reset.done", 64'(done), 0);
    check("reset.addr", 64'(bram_addr), 0);
    check("reset.dataA", bram_dataA, 0);
    check("reset.dataB", bram_dataB, 0);

    // Idle with no start for 100 cycles
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bram_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
          bram_addr !== '0 || bram_dataA !== '0 || bram_dataB !== '0) bad++;
    end
    check("idle.activity", bad, 0);

    // Ramp pattern A = (r*32+c) mod 128, B = -A
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        set_elem(1'b0, r, c, (r*32 + c) % 128);
        set_elem(1'b1, r, c, -((r*32 + c) % 128));
      end
    end
    run_pass("ramp", 1'b0, 1'b0, 1'b0);
    check("ramp.a_last", got_a[N-1], 127);
    check("ramp.b_last", got_b[N-1], -127);
    tick();
    check("ramp.single_done", 64'(done), 0);

    // Sources cleared right after start; snapshot must still be written
    randomize_mats();
    run_pass("snapshot", 1'b0, 1'b1, 1'b0);
    tick();

    // Narrowing corner values
    randomize_mats();
    set_elem(1'b0, 0, 0, 300);
    set_elem(1'b0, 0, 1, -300);
    set_elem(1'b0, 0, 2, 127);
    run_pass("narrow", 1'b0, 1'b0, 1'b0);
`ifdef FSM_BRAM_WRITER_SAT_EN
    check("narrow.a0", got_a[0], 127);
    check("narrow.a1", got_a[1], -128);
`else
    check("narrow.a0", got_a[0], 44);
    check("narrow.a1", got_a[1], -44);
`endif
    check("narrow.a2", got_a[2], 127);
    tick();

    // Start pulse mid-transfer is ignored
    randomize_mats();
    run_pass("midstart", 1'b0, 1'b0, 1'b1);
    tick();
    check("midstart.single_done", 64'(done), 0);
    check("midstart.idle_busy", 64'(busy), 0);

    // Reset mid-transfer aborts immediately
    randomize_mats();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(bram_we === 1'b1 && int'(bram_addr) == 500) && k < N + 20) begin
      tick();
      k++;
    end
    check("abort.reached_500", 64'(bram_we === 1'b1 && int'(bram_addr) == 500), 1);
    rst = 1'b1;
    tick();
    check("abort.we", 64'(bram_we), 0);
    check("abort.busy", 64'(busy), 0);
    check("abort.done", 64'(done), 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("abort.stays_idle", bad, 0);
    randomize_mats();
    run_pass("after_abort", 1'b0, 1'b0, 1'b0);
    tick();

    // Start held high: back-to-back passes with one IDLE cycle (the done cycle)
    randomize_mats();
    run_pass("held1", 1'b1, 1'b0, 1'b0);
    run_pass("held2", 1'b0, 1'b0, 1'b0);
    tick();
    check("held.final_idle", 64'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
